shift_seq: RTL and testbench
============================

SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 32 bits and the shift amount at 8 bits.
REQ-002 clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  synchronous abort of any operation in progress.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request; SHALL equal (state==IDLE).
REQ-007 a  input  32  operand to shift.
REQ-008 amt  input  8  shift amount (Rs bottom byte).
REQ-009 typ  input  2  shift type: 00 LSL, 01 LSR, 10 ASR, 11 ROR/RRX.
REQ-010 carry_in  input  1  current C flag.
REQ-011 y  output  32  registered shift result.
REQ-012 carry_out  output  1  registered shifter carry-out.
REQ-013 out_valid  output  1  result valid; SHALL equal (state==DONE).
REQ-014 out_ready  input  1  consumer accepts the result.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-016 The block SHALL accept a request when in_valid&in_ready is high at a clock edge.
REQ-017 On accept, the block SHALL latch y<=a, the type, and the step count N.
REQ-018 Step count N SHALL be:
- LSL/LSR: min(amt,33).
- ASR: min(amt,32).
- ROR: amt mod 32.
REQ-019 On accept with N>0, the block SHALL go to SHIFT with carry_out unchanged.
REQ-020 On accept with N==0, the block SHALL go directly to DONE and set y and carry_out as follows:
- amt==0, typ!=11: y=a, carry_out=carry_in.
- typ==11, amt==0 (RRX): y={carry_in,a[31:1]}, carry_out=a[0].
- typ==11, amt nonzero multiple of 32: y=a, carry_out=a[31].
REQ-021 In SHIFT, each edge SHALL perform one 1-bit step and decrement the remaining count:
- LSL: carry<=y[31], y<=y<<1.
- LSR: carry<=y[0], y<=y>>1.
- ASR: carry<=y[0], y<={y[31],y[31:1]}.
- ROR: carry<=y[0], y<={y[0],y[31:1]}.
REQ-022 The edge performing the last step SHALL move the state to DONE.
REQ-023 Latency: if the accepting edge is E0, out_valid SHALL be high immediately after edge E0+N.
REQ-024 The implied amount limits SHALL hold:
- LSL/LSR amt>=33: y=0, carry_out=0.
- LSL/LSR amt==32: y=0, carry_out=a[0] (LSL) or a[31] (LSR).
- ASR amt>=32: y=all copies of a[31], carry_out=a[31].
REQ-025 In DONE, y and carry_out SHALL hold stable until out_valid&out_ready is high at an edge, which moves the state to IDLE.
REQ-026 A new request SHALL NOT be accepted in the same cycle as a result handoff; at least one IDLE cycle SHALL separate them.
REQ-027 a, amt, typ and carry_in SHALL be ignored except at the accepting edge; changing them mid-operation SHALL NOT affect the result.
REQ-028 flush high at an edge SHALL force the state to IDLE from any state and discard the pending result, leaving y and carry_out unchanged.
REQ-029 flush SHALL take priority over accept, step and handoff.
REQ-030 in_valid with flush high in the same cycle SHALL NOT be accepted.

Reset
REQ-031 reset high at an edge SHALL force state=IDLE, y=0, carry_out=0, out_valid=0 and step count=0.
REQ-032 After reset, in_ready SHALL be 1.
REQ-033 reset SHALL override flush and all handshakes, including an operation mid-SHIFT or a result held in DONE.
REQ-034 While reset is high, requests SHALL NOT be accepted.

Verification
REQ-035 LSL: a=0x8000_0001, amt=1, typ=00 -> y=0x0000_0002, carry_out=1, out_valid after E0+1.
REQ-036 ROR: a=0x0000_00F1, amt=4 -> y=0x1000_000F, carry_out=0, after E0+4. RRX: a=0x0000_0003, amt=0, carry_in=1, typ=11 -> y=0x8000_0001, carry_out=1, after E0.
REQ-037 ASR: a=0x8000_0000, amt=200 -> y=0xFFFF_FFFF, carry_out=1, after E0+32. LSR: amt=40 -> y=0, carry_out=0, after E0+33.
REQ-038 Back-pressure: hold out_ready=0 for 5 cycles in DONE -> y and carry_out stable, in_ready=0, in_valid ignored. Raise out_ready -> IDLE on the next edge.
REQ-039 Abort: assert flush at E0+3 of an LSL by 20 -> IDLE next cycle, out_valid never asserted. Assert reset mid-SHIFT -> y=0, carry_out=0, in_ready=1.
REQ-040 LSL/LSR amt=0 with carry_in=1 -> y=a, carry_out=1 after E0. ROR amt=64, a=0x8000_0000 -> y=a, carry_out=1.

Source files
------------

// File: rtl/shift_seq.sv
// Multi-cycle barrel-shifter replacement: shifts a 32-bit operand one bit per clock
// with carry-out, using a three-state valid/ready handshake on both sides.
module shift_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [7:0]  amt,
  input  logic [1:0]  typ,
  input  logic        carry_in,
  output logic [31:0] y,
  output logic        carry_out,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [1:0]  typ_q;
  logic [5:0]  cnt;
  logic [5:0]  n;

  // Step count: 33 shifts clear LSL/LSR completely, ASR saturates at 32, ROR wraps.
  always_comb begin
    n = 6'd0;
    case (typ)
      2'b10:   n = (amt >= 8'd32) ? 6'd32 : amt[5:0];
      2'b11:   n = {1'b0, amt[4:0]};
      default: n = (amt >= 8'd33) ? 6'd33 : amt[5:0];
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      y         <= 32'd0;
      carry_out <= 1'b0;
      cnt       <= 6'd0;
      typ_q     <= 2'b00;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            typ_q <= typ;
            cnt   <= n;
            if (n == 6'd0) begin
              state <= DONE;
              if (typ != 2'b11) begin
                y         <= a;
                carry_out <= carry_in;
              end else if (amt == 8'd0) begin
                // RRX: rotate right by one through the carry flag
                y         <= {carry_in, a[31:1]};
                carry_out <= a[0];
              end else begin
                y         <= a;
                carry_out <= a[31];
              end
            end else begin
              y     <= a;
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          case (typ_q)
            2'b00: begin
              carry_out <= y[31];
              y         <= {y[30:0], 1'b0};
            end
            2'b01: begin
              carry_out <= y[0];
              y         <= {1'b0, y[31:1]};
            end
            2'b10: begin
              carry_out <= y[0];
              y         <= {y[31], y[31:1]};
            end
            default: begin
              carry_out <= y[0];
              y         <= {y[0], y[31:1]};
            end
          endcase
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed corner cases plus randomized operations
// compared against an arithmetic reference of the shift rules.
module tb_shift_seq;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [31:0] a, y;
  logic [7:0]  amt;
  logic [1:0]  typ;
  logic        carry_in, carry_out, out_valid, out_ready;

  int compared   = 0;
  int mismatched = 0;

  shift_seq dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .amt(amt), .typ(typ), .carry_in(carry_in), .y(y), .carry_out(carry_out),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: the whole shift computed in one go from the amount rules.
  function automatic void refShift(input logic [31:0] op, input int sh, input logic [1:0] t,
                                   input logic cin, output logic [31:0] ry, output logic rc,
                                   output int steps);
    int r;
    ry = op; rc = cin;
    case (t)
      2'b00: begin
        steps = (sh > 33) ? 33 : sh;
        if (sh == 0) begin ry = op; rc = cin; end
        else if (sh < 32) begin ry = op << sh; rc = op[32 - sh]; end
        else if (sh == 32) begin ry = 0; rc = op[0]; end
        else begin ry = 0; rc = 1'b0; end
      end
      2'b01: begin
        steps = (sh > 33) ? 33 : sh;
        if (sh == 0) begin ry = op; rc = cin; end
        else if (sh < 32) begin ry = op >> sh; rc = op[sh - 1]; end
        else if (sh == 32) begin ry = 0; rc = op[31]; end
        else begin ry = 0; rc = 1'b0; end
      end
      2'b10: begin
        steps = (sh > 32) ? 32 : sh;
        if (sh == 0) begin ry = op; rc = cin; end
        else if (sh < 32) begin ry = $unsigned($signed(op) >>> sh); rc = op[sh - 1]; end
        else begin ry = {32{op[31]}}; rc = op[31]; end
      end
      default: begin
        r = sh % 32;
        steps = r;
        if (sh == 0) begin ry = {cin, op[31:1]}; rc = op[0]; end
        else if (r == 0) begin ry = op; rc = op[31]; end
        else begin ry = (op >> r) | (op << (32 - r)); rc = op[r - 1]; end
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation: accept, scrambled inputs while busy, back-pressure, handoff.
  task automatic applyStimulus(input logic [31:0] op, input int sh, input logic [1:0] t,
                               input logic cin, input int hold);
    logic [31:0] ey;
    logic        ec;
    int          en, k;
    refShift(op, sh, t, cin, ey, ec, en);
    checkOutput("ready_before_accept", {31'd0, in_ready}, 32'd1);
    a = op; amt = sh[7:0]; typ = t; carry_in = cin; in_valid = 1'b1;
    tick();
    a = $urandom; amt = 8'($urandom); typ = 2'($urandom); carry_in = 1'($urandom);
    k = 0;
    while (!out_valid && k < 100) begin
      tick();
      a = $urandom; amt = 8'($urandom);
      k++;
    end
    checkOutput($sformatf("latency t=%0d amt=%0d", t, sh), k, en);
    checkOutput($sformatf("y t=%0d amt=%0d", t, sh), y, ey);
    checkOutput($sformatf("carry t=%0d amt=%0d", t, sh), {31'd0, carry_out}, {31'd0, ec});
    for (int i = 0; i < hold; i++) tick();
    if (hold > 0) begin
      checkOutput("hold_y", y, ey);
      checkOutput("hold_carry", {31'd0, carry_out}, {31'd0, ec});
      checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("hold_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("handoff_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("handoff_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 32'd0; amt = 8'd0; typ = 2'b00; carry_in = 1'b0;
    tick(); tick();
    checkOutput("reset_y", y, 32'd0);
    checkOutput("reset_carry", {31'd0, carry_out}, 32'd0);
    checkOutput("reset_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1;
    tick();
    checkOutput("reset_blocks_accept", {31'd0, in_ready}, 32'd1);
    reset = 1'b0; in_valid = 1'b0;
    tick();

    applyStimulus(32'h8000_0001, 1,   2'b00, 1'b0, 0);
    applyStimulus(32'h0000_00F1, 4,   2'b11, 1'b0, 0);
    applyStimulus(32'h0000_0003, 0,   2'b11, 1'b1, 0);
    applyStimulus(32'h8000_0000, 200, 2'b10, 1'b0, 0);
    applyStimulus(32'h8000_0000, 40,  2'b01, 1'b1, 0);
    applyStimulus(32'h1234_5678, 0,   2'b00, 1'b1, 0);
    applyStimulus(32'h1234_5678, 0,   2'b01, 1'b1, 0);
    applyStimulus(32'h8000_0000, 64,  2'b11, 1'b0, 0);
    applyStimulus(32'hA5A5_0001, 32,  2'b00, 1'b0, 5);
    applyStimulus(32'h8765_4321, 32,  2'b01, 1'b0, 2);
    applyStimulus(32'h8765_4321, 33,  2'b00, 1'b1, 0);

    // Flush arriving at the third edge after accept of an LSL by 20.
    a = 32'h0000_0F0F; amt = 8'd20; typ = 2'b00; carry_in = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_idle", {31'd0, in_ready}, 32'd1);
    checkOutput("flush_y_frozen", y, 32'h0000_0F0F << 2);
    begin
      int seen = 0;
      for (int i = 0; i < 30; i++) begin
        if (out_valid) seen++;
        tick();
      end
      checkOutput("flush_no_valid", seen, 0);
    end

    // Flush wins over a simultaneous request.
    in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("flush_blocks_accept", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of a shift.
    a = 32'hFFFF_FFFF; amt = 8'd20; typ = 2'b00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midreset_y", y, 32'd0);
    checkOutput("midreset_carry", {31'd0, carry_out}, 32'd0);
    checkOutput("midreset_ready", {31'd0, in_ready}, 32'd1);
    tick();

    for (int i = 0; i < 40; i++) begin
      int sh;
      sh = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 40);
      applyStimulus($urandom, sh, 2'($urandom), 1'($urandom), $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
